// File: rtl/nic8_input_port.sv
// nic8 byte input port: valid/ready source into a small FIFO, read onto dbus by assertBarI.
// Define NIC8_INPUT_UNDERRUN_EN to build the saturating underrun counter.
module nic8_input_port #(
    parameter int          DEPTH       = 4,
    parameter logic [7:0]  EMPTY_VALUE = 8'hFF
) (
    input  logic                       clk,
    input  logic                       resetBar,
    input  logic [7:0]                 src_data,
    input  logic                       src_valid,
    output logic                       src_ready,
    input  logic                       assertBarI,
    output logic [7:0]                 dbus_out,
    output logic                       dbus_oe,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 underruns
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign src_ready = ~full;
    assign push      = src_valid & src_ready;
    assign pop       = ~assertBarI & ~empty;
    assign dbus_oe   = ~assertBarI;
    assign dbus_out  = empty ? EMPTY_VALUE : mem[rd_ptr];

    // Storage is not reset; count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef NIC8_INPUT_UNDERRUN_EN
    logic [7:0] ur_q;

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            ur_q <= '0;
        end else if (~assertBarI && empty && (ur_q != 8'hFF)) begin
            ur_q <= ur_q + 8'd1;
        end
    end

    assign underruns = ur_q;
`else
    assign underruns = 8'h00;
`endif

endmodule

// File: tb/tb_nic8_input_port.sv
// Randomized and directed bench for nic8_input_port against a queue-based model.
// Expected underrun behaviour follows NIC8_INPUT_UNDERRUN_EN.
module tb_nic8_input_port;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetBar = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic       assertBarI = 1'b1;
    logic [7:0] dbus_out;
    logic       dbus_oe;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic [7:0] underruns;

    int total = 0;
    int bad = 0;

    byte unsigned exp_q[$];
    int           ur_m = 0;
    int           popped = 0;

    nic8_input_port #(.DEPTH(DEPTH), .EMPTY_VALUE(8'hFF)) dut (
        .clk        (clk),
        .resetBar   (resetBar),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .assertBarI (assertBarI),
        .dbus_out   (dbus_out),
        .dbus_oe    (dbus_oe),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .underruns  (underruns)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue, a push needs room before any same-cycle pop.
    always @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            exp_q.delete();
            ur_m <= 0;
        end else begin
            automatic bit do_push = src_valid && (exp_q.size() < DEPTH);
            automatic bit do_pop  = !assertBarI && (exp_q.size() > 0);
            if (!assertBarI && exp_q.size() == 0 && ur_m < 255) begin
`ifdef NIC8_INPUT_UNDERRUN_EN
                ur_m <= ur_m + 1;
`endif
            end
            if (do_pop) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (do_push) begin
                exp_q.push_back(src_data);
            end
        end
    end

    // Monitor compares every visible output mid-cycle.
    always @(negedge clk) begin
        automatic int n = exp_q.size();
        check("dbus_oe", int'(dbus_oe), int'(!assertBarI));
        check("count", int'(count), n);
        check("empty", int'(empty), int'(n == 0));
        check("full", int'(full), int'(n == DEPTH));
        check("src_ready", int'(src_ready), int'(n < DEPTH));
        check("dbus_out", int'(dbus_out), (n > 0) ? int'(exp_q[0]) : 32'hFF);
        check("underruns", int'(underruns), ur_m);
    end

    task automatic step(input logic v, input logic [7:0] d, input logic rd);
        src_valid  = v;
        src_data   = d;
        assertBarI = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        byte unsigned vals[4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        // reset then idle
        @(posedge clk); #1;
        step(0, 8'h00, 1);
        resetBar = 1'b1;
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);

        // fill, hold off a fifth byte, drain in order
        for (int i = 0; i < 4; i++) step(1, vals[i], 1);
        check("full_after_fill", int'(full), 1);
        step(1, 8'h55, 1);
        step(1, 8'h55, 1);
        check("held_off_count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b0; assertBarI = 1'b0;
            #1;
            check("drain_order", int'(dbus_out), int'(vals[i]));
            @(posedge clk); #1;
        end
        assertBarI = 1'b1;
        check("empty_after_drain", int'(empty), 1);

        // simultaneous push/pop with wrap
        step(1, 8'h01, 1);
        step(1, 8'h02, 1);
        for (int i = 0; i < 12; i++) begin
            step(1, 8'hA5 + 8'(i), 0);
            check("pushpop_count", int'(count), 2);
        end
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);

        // empty read with same-cycle push
        src_valid = 1'b1; src_data = 8'h7E; assertBarI = 1'b0;
        #1;
        check("empty_read_ff", int'(dbus_out), 8'hFF);
        @(posedge clk); #1;
        src_valid = 1'b0;
        #1;
        check("after_empty_push_count", int'(count), 1);
        check("after_empty_push_data", int'(dbus_out), 8'h7E);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);

        // async reset mid-operation
        step(1, 8'hC1, 1);
        step(1, 8'hC2, 1);
        step(1, 8'hC3, 1);
        src_valid = 1'b0;
        check("pre_reset_count", int'(count), 3);
        #2 resetBar = 1'b0;
        #1;
        check("async_count", int'(count), 0);
        check("async_empty", int'(empty), 1);
        check("async_ready", int'(src_ready), 1);
        @(posedge clk); #1;
        resetBar = 1'b1;
        step(0, 8'h00, 1);
        assertBarI = 1'b0;
        #1;
        check("post_reset_read", int'(dbus_out), 8'hFF);
        @(posedge clk); #1;

        // underrun saturation
        for (int i = 0; i < 300; i++) step(0, 8'h00, 0);
        assertBarI = 1'b1;
`ifdef NIC8_INPUT_UNDERRUN_EN
        check("underrun_sat", int'(underruns), 8'hFF);
`else
        check("underrun_off", int'(underruns), 8'h00);
`endif
        check("underrun_empty", int'(empty), 1);

        // randomized traffic with varying bias
        for (int i = 0; i < 3000; i++) begin
            automatic int bias = (i / 500) % 3;
            automatic logic v  = ($urandom_range(0, 3) < (bias + 1));
            automatic logic rd = !($urandom_range(0, 3) < (3 - bias));
            step(v, 8'($urandom), rd);
        end
        step(0, 8'h00, 1);
        check("popped_any", int'(popped > 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
